// File: rtl/ky32_pkg.sv
// Shared KY32 register-file constants and helpers used by the write-back scheduler.
package ky32_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int XLEN       = 32;

  function automatic logic [NUM_REGS-1:0] onehot5to32(input logic [REG_ADDR_W-1:0] idx);
    logic [NUM_REGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ky32_wb_sched_if.sv
// Issue, write-back source and register-file write-port bundle of the KY32 write-back scheduler.
interface ky32_wb_sched_if #(
  parameter int NSRC = 2,
  parameter int XLEN = 32
);

  logic                   issue_valid;
  logic [4:0]             issue_rs1;
  logic [4:0]             issue_rs2;
  logic [4:0]             issue_rd;
  logic                   issue_rd_we;
  logic                   issue_ready;
  logic [NSRC-1:0]        src_valid;
  logic [5*NSRC-1:0]      src_rd;
  logic [XLEN*NSRC-1:0]   src_data;
  logic [NSRC-1:0]        src_ready;
  logic                   rf_we;
  logic [4:0]             rf_w_addr;
  logic [XLEN-1:0]        rf_wd;

  // issue stage and execution units
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
    output src_valid, src_rd, src_data,
    input  issue_ready, src_ready, rf_we, rf_w_addr, rf_wd
  );

  // scheduler
  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we,
    input  src_valid, src_rd, src_data,
    output issue_ready, src_ready, rf_we, rf_w_addr, rf_wd
  );

endinterface

// File: rtl/ky32_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered pointer.
module ky32_rr_arb #(
  parameter int NSRC = 2,
  parameter int IW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] req,
  input  logic            advance,
  output logic [NSRC-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  localparam int SW = IW + 1;

  logic [IW-1:0] ptr_r;
  logic          found_s;
  logic [SW-1:0] sum_s;
  logic [IW-1:0] idx_s;

  // first requester at or after the pointer, wrapping modulo NSRC
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found_s   = 1'b0;
    sum_s     = '0;
    idx_s     = '0;
    for (int i = 0; i < NSRC; i++) begin
      sum_s = {1'b0, ptr_r} + SW'(i);
      if (sum_s >= SW'(NSRC)) begin
        sum_s = sum_s - SW'(NSRC);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IW-1:0];
      if (!found_s && req[idx_s]) begin
        found_s      = 1'b1;
        grant[idx_s] = 1'b1;
        grant_idx    = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // pointer moves past the winner; holds when nothing was granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= (grant_idx == IW'(NSRC - 1)) ? '0 : grant_idx + IW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/ky32_wb_sched.sv
// KY32 write-back scheduler: shares the RF write port among NSRC producers and
// tracks per-register busy bits to stall issue on RAW/WAW hazards.
module ky32_wb_sched #(
  parameter int NSRC = 2,
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  ky32_wb_sched_if.slave     bus,
  output logic [31:0]        busy_o,
  output logic               err_o
);

  import ky32_pkg::*;

  localparam int IW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]       req_s;
  logic [NSRC-1:0]       grant_s;
  logic [IW-1:0]         gidx_s;
  logic                  grant_any_s;
  logic [REG_ADDR_W-1:0] g_rd_s;
  logic [XLEN-1:0]       g_data_s;
  logic [NUM_REGS-1:0]   busy_r;
  logic [NUM_REGS-1:0]   supp_r;
  logic [NUM_REGS-1:0]   set_s;
  logic [NUM_REGS-1:0]   clr_s;
  logic                  hz_s;
  logic                  err_set_s;
  logic                  err_r;

  // requests are masked while reset is held so no grant leaks out
  assign req_s       = rst ? bus.src_valid : '0;
  assign grant_any_s = |grant_s;

  ky32_rr_arb #(.NSRC(NSRC), .IW(IW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_s),
    .advance   (grant_any_s),
    .grant     (grant_s),
    .grant_idx (gidx_s)
  );

  // hazard check and busy-set request from the issue stage
  always_comb begin
    hz_s = busy_r[bus.issue_rs1] | busy_r[bus.issue_rs2] |
           (bus.issue_rd_we & busy_r[bus.issue_rd]);
    bus.issue_ready = ~hz_s;
    if (bus.issue_valid && !hz_s && bus.issue_rd_we && (bus.issue_rd != 5'd0)) begin
      set_s = onehot5to32(bus.issue_rd);
    end else begin
      set_s = '0;
    end
  end

  // zero-latency write-port mux from the granted source
  always_comb begin
    g_rd_s   = '0;
    g_data_s = '0;
    if (grant_any_s) begin
      g_rd_s   = bus.src_rd[int'(gidx_s)*REG_ADDR_W +: REG_ADDR_W];
      g_data_s = bus.src_data[int'(gidx_s)*XLEN +: XLEN];
    end else begin
      g_rd_s   = '0;
      g_data_s = '0;
    end
    bus.src_ready = grant_s;
    bus.rf_we     = grant_any_s & (g_rd_s != 5'd0);
    bus.rf_w_addr = g_rd_s;
    bus.rf_wd     = g_data_s;
    clr_s         = bus.rf_we ? onehot5to32(g_rd_s) : '0;
    // a retire to an idle register is a protocol error unless it was flushed away
    err_set_s     = bus.rf_we & ~busy_r[g_rd_s] & ~supp_r[g_rd_s];
  end

  // busy mask: set wins over clear, flush overrides both
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= '0;
    end else if (flush) begin
      busy_r <= '0;
    end else begin
      busy_r <= (busy_r & ~clr_s) | set_s;
    end
  end

  // flushed registers keep an error-suppress bit until they are issued again
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      supp_r <= '0;
    end else if (flush) begin
      supp_r <= supp_r | busy_r | set_s;
    end else begin
      supp_r <= supp_r & ~set_s;
    end
  end

  // sticky protocol error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign busy_o = busy_r;
  assign err_o  = err_r;

endmodule

// File: tb/tb_ky32_wb_sched.sv
// Scoreboard bench for ky32_wb_sched: stimulus queues expected write-port beats,
// a negedge monitor pops and compares them whenever a source is granted.
module tb_ky32_wb_sched;

  localparam int NSRC = 2;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [NSRC-1:0] ready;
    logic            we;
    logic [4:0]      addr;
    logic [31:0]     data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] busy_o;
  logic        err_o;

  wb_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  always #5 clk = ~clk;

  ky32_wb_sched_if #(.NSRC(NSRC), .XLEN(XLEN)) sif ();

  ky32_wb_sched #(.NSRC(NSRC), .XLEN(XLEN)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .bus    (sif),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_src(input int i, input logic [4:0] rd, input logic [31:0] data);
    sif.src_valid[i]            = 1'b1;
    sif.src_rd[i*5 +: 5]        = rd;
    sif.src_data[i*XLEN +: XLEN] = data;
  endtask

  task automatic push_exp(input logic [NSRC-1:0] rdy, input logic we, input logic [4:0] a,
                          input logic [31:0] d);
    wb_t e;
    e.ready = rdy;
    e.we    = we;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic issue_one(input logic [4:0] rd);
    sif.issue_valid = 1'b1;
    sif.issue_rd    = rd;
    sif.issue_rd_we = 1'b1;
    @(negedge clk);
    tick();
    sif.issue_valid = 1'b0;
    sif.issue_rd_we = 1'b0;
  endtask

  // monitor: every grant must match the next queued write-port beat
  always @(negedge clk) begin
    if (sif.src_ready !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(sif.src_ready), 32'd0);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("src_ready", 32'(sif.src_ready), 32'(e.ready));
        check("rf_we", 32'(sif.rf_we), 32'(e.we));
        check("rf_w_addr", 32'(sif.rf_w_addr), 32'(e.addr));
        check("rf_wd", sif.rf_wd, e.data);
      end
    end
  end

  initial begin
    sif.issue_valid = 1'b0;
    sif.issue_rs1   = 5'd0;
    sif.issue_rs2   = 5'd0;
    sif.issue_rd    = 5'd0;
    sif.issue_rd_we = 1'b0;
    sif.src_valid   = '0;
    sif.src_rd      = '0;
    sif.src_data    = '0;

    // reset: a pending source must not be granted while rst is low
    drive_src(0, 5'd3, 32'h0000_0055);
    tick();
    @(negedge clk);
    check("rst_src_ready", 32'(sif.src_ready), 32'd0);
    check("rst_rf_we", 32'(sif.rf_we), 32'd0);
    check("rst_rf_wd", sif.rf_wd, 32'd0);
    check("rst_issue_ready", 32'(sif.issue_ready), 32'd1);
    check("rst_busy", busy_o, 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    tick();
    sif.src_valid = '0;
    rst = 1'b1;

    // basic issue -> RAW stall -> retire
    sif.issue_valid = 1'b1;
    sif.issue_rd    = 5'd5;
    sif.issue_rd_we = 1'b1;
    @(negedge clk);
    check("t1_issue_ready", 32'(sif.issue_ready), 32'd1);
    tick();
    sif.issue_valid = 1'b0;
    sif.issue_rd_we = 1'b0;
    sif.issue_rs1   = 5'd5;
    @(negedge clk);
    check("t1_busy_set", busy_o, 32'h0000_0020);
    check("t1_raw_stall", 32'(sif.issue_ready), 32'd0);
    tick();
    drive_src(0, 5'd5, 32'hDEAD_BEEF);
    push_exp(2'b01, 1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    check("t1_no_bypass", 32'(sif.issue_ready), 32'd0);
    tick();
    sif.src_valid = '0;
    @(negedge clk);
    check("t1_busy_clr", busy_o, 32'd0);
    check("t1_ready_again", 32'(sif.issue_ready), 32'd1);
    tick();
    sif.issue_rs1 = 5'd0;

    // preset busy[1], busy[2]; then an rd=0 retire from src1 leaves them alone
    issue_one(5'd1);
    issue_one(5'd2);
    drive_src(1, 5'd0, 32'h0000_1234);
    push_exp(2'b10, 1'b0, 5'd0, 32'h0000_1234);
    @(negedge clk);
    tick();
    sif.src_valid = '0;
    @(negedge clk);
    check("t4_busy_kept", busy_o, 32'h0000_0006);
    check("t4_no_err", 32'(err_o), 32'd0);
    tick();

    // two rounds of both sources valid: grants alternate 0,1,0,1
    for (int r = 0; r < 2; r++) begin
      if (r > 0) begin
        issue_one(5'd1);
        issue_one(5'd2);
      end
      drive_src(0, 5'd1, 32'h1111_0000 + 32'(r));
      drive_src(1, 5'd2, 32'h2222_0000 + 32'(r));
      push_exp(2'b01, 1'b1, 5'd1, 32'h1111_0000 + 32'(r));
      push_exp(2'b10, 1'b1, 5'd2, 32'h2222_0000 + 32'(r));
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      sif.src_valid = '0;
      @(negedge clk);
      check("t2_busy_drained", busy_o, 32'd0);
      check("t2_no_err", 32'(err_o), 32'd0);
      tick();
    end

    // WAW: rd=7 stays blocked until its pending write retires
    issue_one(5'd7);
    sif.issue_valid = 1'b1;
    sif.issue_rd    = 5'd7;
    sif.issue_rd_we = 1'b1;
    @(negedge clk);
    check("t3_waw_stall0", 32'(sif.issue_ready), 32'd0);
    tick();
    @(negedge clk);
    check("t3_waw_stall1", 32'(sif.issue_ready), 32'd0);
    tick();
    drive_src(0, 5'd7, 32'h0000_0077);
    push_exp(2'b01, 1'b1, 5'd7, 32'h0000_0077);
    @(negedge clk);
    check("t3_waw_retire_cycle", 32'(sif.issue_ready), 32'd0);
    tick();
    sif.src_valid = '0;
    @(negedge clk);
    check("t3_waw_release", 32'(sif.issue_ready), 32'd1);
    tick();
    sif.issue_valid = 1'b0;
    sif.issue_rd_we = 1'b0;
    @(negedge clk);
    check("t3_rd7_reissued", busy_o, 32'h0000_0080);
    tick();

    // retire to an idle register: write performed, sticky error
    drive_src(1, 5'd9, 32'h0000_0099);
    push_exp(2'b10, 1'b1, 5'd9, 32'h0000_0099);
    @(negedge clk);
    check("t5_err_before", 32'(err_o), 32'd0);
    tick();
    sif.src_valid = '0;
    @(negedge clk);
    check("t5_err_set", 32'(err_o), 32'd1);
    tick();
    tick();
    tick();
    @(negedge clk);
    check("t5_err_sticky", 32'(err_o), 32'd1);
    tick();

    // move the pointer to 1, then reset mid-stream with requests pending
    drive_src(0, 5'd0, 32'h0000_00A0);
    push_exp(2'b01, 1'b0, 5'd0, 32'h0000_00A0);
    @(negedge clk);
    tick();
    sif.src_valid = '0;
    sif.issue_rs1 = 5'd7;
    @(negedge clk);
    check("t6_busy_pre", busy_o, 32'h0000_0080);
    check("t6_stall_pre", 32'(sif.issue_ready), 32'd0);
    #2;
    rst = 1'b0;
    drive_src(0, 5'd0, 32'h0000_00B0);
    drive_src(1, 5'd0, 32'h0000_00B1);
    #1;
    check("t6_async_busy", busy_o, 32'd0);
    check("t6_async_err", 32'(err_o), 32'd0);
    check("t6_async_src_ready", 32'(sif.src_ready), 32'd0);
    check("t6_async_rf_we", 32'(sif.rf_we), 32'd0);
    check("t6_async_issue_ready", 32'(sif.issue_ready), 32'd1);
    tick();
    tick();
    push_exp(2'b01, 1'b0, 5'd0, 32'h0000_00B0);
    push_exp(2'b10, 1'b0, 5'd0, 32'h0000_00B1);
    rst = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    sif.src_valid = '0;
    sif.issue_rs1 = 5'd0;
    @(negedge clk);
    check("t6_err_after_rst", 32'(err_o), 32'd0);
    tick();

    // flush clears the mask; a late retire of a flushed register is no error
    issue_one(5'd10);
    issue_one(5'd11);
    @(negedge clk);
    check("t7_busy_pre_flush", busy_o, 32'h0000_0C00);
    tick();
    flush = 1'b1;
    @(negedge clk);
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("t7_busy_flushed", busy_o, 32'd0);
    tick();
    drive_src(0, 5'd10, 32'h0000_AAAA);
    push_exp(2'b01, 1'b1, 5'd10, 32'h0000_AAAA);
    @(negedge clk);
    tick();
    sif.src_valid = '0;
    @(negedge clk);
    check("t7_no_err", 32'(err_o), 32'd0);
    check("t7_busy_after", busy_o, 32'd0);
    tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
